// File: rtl/data_bus_arbiter_pkg.sv
// Shared bus definitions for the data-bus arbiter slice: default widths and master IDs.
package pixracer_bus_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef logic mid_t;

  localparam mid_t MID_CORE = 1'b0;
  localparam mid_t MID_AUX  = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// One req/gnt/rvalid bus port; "master" drives the request, "slave" answers it.
interface data_bus_arbiter_if
  import pixracer_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic            req;
  logic [AW-1:0]   addr;
  logic            we;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/data_bus_arbiter_id_fifo.sv
// Small circular FIFO holding the master ID of each granted-but-unanswered transaction.
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == CW'(0));
  assign head_o  = mem_q[rptr_q];

  // A pop frees a slot first, so push is accepted at full only alongside a pop.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    wptr_d    = do_push_s ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = do_pop_s ? ptr_inc(rptr_q) : rptr_q;
    cnt_d     = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the data-bus slave; responses are routed back by an ID FIFO.
// Optional ARB_STALL_CNT_EN adds per-master saturating stall counters.
module data_bus_arbiter
  import pixracer_bus_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAX_OUT = 2
) (
  input  logic                HCLK,
  input  logic                HRESET,
  data_bus_arbiter_if.slave   m0,
  data_bus_arbiter_if.slave   m1,
  data_bus_arbiter_if.master  s,
  output logic                rsp_err
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt0,
  output logic [15:0]         stall_cnt1
`endif
);

  mid_t            win_s, head_s, last_win_q, last_win_d;
  logic            full_s, empty_s, sreq_s, push_s, pop_s;
  logic            rsp_err_q, rsp_err_d;
  logic [AW-1:0]   addr_s;
  logic            we_s;
  logic [DW/8-1:0] be_s;
  logic [DW-1:0]   wdata_s;

  // On conflict the master that did not win last time gets the bus.
  always_comb begin
    if (m0.req && m1.req) begin
      win_s = ~last_win_q;
    end else if (m1.req) begin
      win_s = MID_AUX;
    end else begin
      win_s = MID_CORE;
    end
  end

  always_comb begin
    sreq_s  = (m0.req | m1.req) & ~full_s;
    addr_s  = '0;
    we_s    = 1'b0;
    be_s    = '0;
    wdata_s = '0;
    if (sreq_s && (win_s == MID_AUX)) begin
      addr_s  = m1.addr;
      we_s    = m1.we;
      be_s    = m1.be;
      wdata_s = m1.wdata;
    end else if (sreq_s) begin
      addr_s  = m0.addr;
      we_s    = m0.we;
      be_s    = m0.be;
      wdata_s = m0.wdata;
    end else begin
      addr_s  = '0;
    end
  end

  assign s.req   = sreq_s;
  assign s.addr  = addr_s;
  assign s.we    = we_s;
  assign s.be    = be_s;
  assign s.wdata = wdata_s;

  assign push_s = sreq_s & s.gnt;
  assign pop_s  = s.rvalid & ~empty_s;

  assign m0.gnt    = push_s & (win_s == MID_CORE);
  assign m1.gnt    = push_s & (win_s == MID_AUX);
  assign m0.rvalid = pop_s & (head_s == MID_CORE);
  assign m1.rvalid = pop_s & (head_s == MID_AUX);
  assign m0.rdata  = (pop_s && (head_s == MID_CORE)) ? s.rdata : '0;
  assign m1.rdata  = (pop_s && (head_s == MID_AUX)) ? s.rdata : '0;

  arb_id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (win_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // A response with nothing outstanding is dropped and latched as an error.
  always_comb begin
    last_win_d = push_s ? win_s : last_win_q;
    rsp_err_d  = rsp_err_q | (s.rvalid & empty_s);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_win_q <= MID_AUX;
      rsp_err_q  <= 1'b0;
    end else begin
      last_win_q <= last_win_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall0_q, stall0_d, stall1_q, stall1_d;

  always_comb begin
    stall0_d = stall0_q;
    stall1_d = stall1_q;
    if (m0.req && !m0.gnt && (stall0_q != 16'hFFFF)) begin
      stall0_d = stall0_q + 16'd1;
    end else begin
      stall0_d = stall0_q;
    end
    if (m1.req && !m1.gnt && (stall1_q != 16'hFFFF)) begin
      stall1_d = stall1_q + 16'd1;
    end else begin
      stall1_d = stall1_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stall0_q <= 16'd0;
      stall1_q <= 16'd0;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end

  assign stall_cnt0 = stall0_q;
  assign stall_cnt1 = stall1_q;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized scoreboard bench for data_bus_arbiter; reference model tracks outstanding count,
// last winner and the expected response order as plain queues and integers.
module tb_data_bus_arbiter;
  import pixracer_bus_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int MAX_OUT = 2;

  logic HCLK = 1'b0;
  logic HRESET;
  logic rsp_err;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt0, stall_cnt1;
`endif

  data_bus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  data_bus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  data_bus_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  always #5 HCLK = ~HCLK;

  data_bus_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .rsp_err (rsp_err)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_cnt0 (stall_cnt0),
    .stall_cnt1 (stall_cnt1)
`endif
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] slv_q[$];
  int            total = 0;
  int            bad   = 0;
  bit            mon_en = 1'b0;

  // reference model state
  int   mcount;
  int   mlast;
  logic exp_err;
  int   cnt[2];

  // master stimulus state
  logic          r[2];
  logic [AW-1:0] a[2];
  logic          we[2];
  logic [BW-1:0] be[2];
  logic [DW-1:0] wd[2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mcount  = 0;
    mlast   = 1;
    exp_err = 1'b0;
    cnt[0]  = 0;
    cnt[1]  = 0;
    sb_q.delete();
    slv_q.delete();
  endtask

  task automatic step(input bit rst, input int p0, input int p1, input int pg, input int prv,
                      input bit frc);
    bit            rv, g, sreq;
    int            w;
    int            pr[2];
    logic [DW-1:0] rd;
    logic [68:0]   exp_bus;
    pr[0] = p0;
    pr[1] = p1;
    @(posedge HCLK);
    #1;
    HRESET = rst;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        r[i] = 1'b0;
      end else if (!r[i] && (int'($urandom_range(99)) < pr[i])) begin
        r[i]  = 1'b1;
        a[i]  = $urandom;
        we[i] = 1'($urandom);
        be[i] = BW'($urandom);
        wd[i] = $urandom;
      end
    end
    m0_if.req = r[0]; m0_if.addr = a[0]; m0_if.we = we[0]; m0_if.be = be[0]; m0_if.wdata = wd[0];
    m1_if.req = r[1]; m1_if.addr = a[1]; m1_if.we = we[1]; m1_if.be = be[1]; m1_if.wdata = wd[1];
    s_if.gnt = !rst && (int'($urandom_range(99)) < pg);
    rv = !rst && (frc || ((slv_q.size() > 0) && (int'($urandom_range(99)) < prv)));
    s_if.rvalid = rv;
    if (rv && (slv_q.size() > 0)) s_if.rdata = slv_q.pop_front();
    else s_if.rdata = $urandom;
    @(negedge HCLK);
    if (rst) begin
      model_reset();
    end else begin
      sreq = (r[0] || r[1]) && (mcount < MAX_OUT);
      w    = (r[0] && r[1]) ? (1 - mlast) : (r[1] ? 1 : 0);
      g    = s_if.gnt && sreq;
      check("s_req", 128'(s_if.req), 128'(sreq));
      check("m0_gnt", 128'(m0_if.gnt), 128'(g && (w == 0)));
      check("m1_gnt", 128'(m1_if.gnt), 128'(g && (w == 1)));
      exp_bus = sreq ? {a[w], we[w], be[w], wd[w]} : 69'd0;
      check("s_bus", 128'({s_if.addr, s_if.we, s_if.be, s_if.wdata}), 128'(exp_bus));
      check("rvalid_any", 128'(m0_if.rvalid | m1_if.rvalid), 128'(rv && (mcount > 0)));
      check("rsp_err", 128'(rsp_err), 128'(exp_err));
`ifdef ARB_STALL_CNT_EN
      check("stall_cnt0", 128'(stall_cnt0), 128'(cnt[0]));
      check("stall_cnt1", 128'(stall_cnt1), 128'(cnt[1]));
`endif
      for (int i = 0; i < 2; i++) begin
        if (r[i] && !(g && (w == i)) && (cnt[i] < 65535)) cnt[i]++;
      end
      if (rv && (mcount == 0)) exp_err = 1'b1;
      if (rv && (mcount > 0)) mcount--;
      if (g) begin
        mlast = w;
        rd    = $urandom;
        slv_q.push_back(rd);
        sb_q.push_back('{w, rd});
        r[w]  = 1'b0;
        mcount++;
      end
    end
  endtask

  // response monitor: any master rvalid must match the oldest outstanding grant
  always @(negedge HCLK) begin
    exp_t e;
    if (mon_en) begin
      if (!m0_if.rvalid) check("m0_rdata_idle", 128'(m0_if.rdata), 128'd0);
      if (!m1_if.rvalid) check("m1_rdata_idle", 128'(m1_if.rdata), 128'd0);
      if (m0_if.rvalid && m1_if.rvalid) begin
        check("rvalid_both", 128'd1, 128'd0);
      end else if (m0_if.rvalid || m1_if.rvalid) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 128'(m1_if.rvalid), 128'hFF);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", 128'(m1_if.rvalid), 128'(e.id));
          check("rsp_data", 128'(m1_if.rvalid ? m1_if.rdata : m0_if.rdata), 128'(e.data));
        end
      end
    end
  end

  initial begin
    HRESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r[i] = 1'b0; a[i] = '0; we[i] = 1'b0; be[i] = '0; wd[i] = '0;
    end
    m0_if.req = 1'b0; m0_if.addr = '0; m0_if.we = 1'b0; m0_if.be = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.addr = '0; m1_if.we = 1'b0; m1_if.be = '0; m1_if.wdata = '0;
    s_if.gnt = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
    model_reset();
    repeat (3) step(1'b1, 0, 0, 0, 0, 1'b0);
    mon_en = 1'b1;
    repeat (2) step(1'b0, 0, 0, 0, 0, 1'b0);           // idle after reset
    repeat (4) step(1'b0, 100, 0, 100, 100, 1'b0);     // m0 alone
    repeat (8) step(1'b0, 100, 100, 100, 100, 1'b0);   // conflict: alternating grants
    repeat (6) step(1'b0, 100, 100, 100, 0, 1'b0);     // no responses: fills, s_req drops
    repeat (8) step(1'b0, 100, 100, 100, 100, 1'b0);   // push+pop at full
    repeat (300) step(1'b0, 60, 60, 70, 50, 1'b0);     // random traffic
    repeat (12) step(1'b0, 0, 0, 100, 100, 1'b0);      // drain
    step(1'b0, 0, 0, 0, 0, 1'b1);                      // response with nothing outstanding
    repeat (4) step(1'b0, 0, 0, 0, 0, 1'b0);           // rsp_err sticky
    repeat (10) step(1'b0, 100, 100, 100, 0, 1'b0);    // build outstanding, m1 stalls
    repeat (2) step(1'b1, 0, 0, 0, 0, 1'b0);           // reset mid-transaction
    repeat (2) step(1'b0, 0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b1);                      // late response after reset
    repeat (3) step(1'b0, 0, 0, 0, 0, 1'b0);
    repeat (150) step(1'b0, 70, 40, 60, 60, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
